decoder_scan_nx: RTL and testbench
==================================

Name: decoder_scan_nx

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It generalises the fixed 3-to-8 combinational decoder.
- Direct mode: the caller supplies a code, qualified by a valid strobe.
- Scan mode: an internal dwell counter steps through codes 0..SCAN_LAST automatically. This mode drives digit/LED select lines on the board.
- Sits between control logic and the board's select pins.

Parameters:
N, 3, code width; output width is 2^N
DWELL, 4, clock cycles each code is held in scan mode (>=1)
SCAN_LAST, 2^N-1, highest code visited in scan mode; legal range 0..2^N-1
OUT_ACTIVE_LOW, 0, 1 = active output bit is 0 and inactive bits are 1

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
en  in  1  block enable
mode  in  1  0 = direct, 1 = scan
code_in  in  N  code for direct mode
code_vld  in  1  code_in valid strobe (direct mode only)
out  out  2^N  registered one-hot (or one-cold) decode
cur_code  out  N  code currently decoded on out
scan_tick  out  1  one-cycle pulse when scan advances

Behaviour:
- Clock and reset: one clock (Clk). Reset is asynchronous and active-low (Rst_n).
- Reset values:
  - out = all inactive (all 0, or all 1 if OUT_ACTIVE_LOW=1)
  - cur_code = 0, scan_tick = 0, dwell counter = 0, FSM = IDLE
- FSM states: IDLE, DIRECT, SCAN. All transitions are evaluated every cycle.
  - en=0 -> IDLE
  - en=1 & mode=0 -> DIRECT
  - en=1 & mode=1 -> SCAN
- IDLE:
  - out goes inactive the cycle after en falls.
  - cur_code holds its value; dwell counter is cleared.
  - code_vld is ignored.
- DIRECT:
  - code_vld=1 at edge k: out = onehot(code_in) and cur_code = code_in, both visible after edge k (latency 1 cycle).
  - No strobe: out and cur_code hold.
  - Entering DIRECT from IDLE: out shows onehot(cur_code) until the first strobe.
  - code_in > SCAN_LAST is accepted; SCAN_LAST limits scan mode only.
- SCAN:
  - Dwell counter runs 0..DWELL-1.
  - On the edge where the counter is at DWELL-1:
    - counter returns to 0
    - cur_code increments, wrapping SCAN_LAST -> 0
    - scan_tick = 1 for exactly that one cycle
  - out always equals the decode of the current cur_code.
  - code_vld is ignored in SCAN.
  - DWELL=1: cur_code advances every cycle and scan_tick is held high.
  - SCAN_LAST=0: cur_code stays at 0 and scan_tick still pulses every DWELL cycles.
- Mode and enable changes:
  - Entering SCAN clears the counter and starts from the present cur_code.
  - If cur_code > SCAN_LAST on entry, the next advance wraps to 0.
  - Leaving SCAN mid-dwell discards the partial count.
  - scan_tick never asserts outside SCAN.
- Simultaneous events: en=0 overrides mode and code_vld in the same cycle.
- Reset mid-operation: all state returns to reset values immediately, without waiting for Clk.
- Widths:
  - Dwell counter width = max(1, $clog2(DWELL)).
  - cur_code increment is N bits and explicitly wrapped at SCAN_LAST.

Optional Feature:
DECODER_SCAN_EN
- Defined: SCAN state, dwell counter and scan_tick logic are built as described above.
- Undefined:
  - mode is ignored and treated as 0.
  - The FSM has only IDLE and DIRECT.
  - scan_tick is tied to 0; DWELL and SCAN_LAST have no effect.
  - No counter flops are synthesised.

Decomposition:
- Package decoder_pkg holds:
  - FSM state typedef (IDLE/DIRECT/SCAN)
  - mode constants MODE_DIRECT=0, MODE_SCAN=1
  - helper function for the dwell counter width
- Sub-module decoder_onehot (combinational N -> 2^N with OUT_ACTIVE_LOW polarity). Instantiated once before the out register.

Test Plan:
- N=3. Reset, then en=1, mode=0, code_vld pulses with code_in=0..7 in turn -> one cycle later out = 8'h01, 8'h02 .. 8'h80; cur_code matches each code.
- mode=0, code_in changes with code_vld=0 -> out and cur_code unchanged.
- DWELL=4, SCAN_LAST=5, mode=1 from cur_code=0:
  - cur_code sequence 0,1,2,3,4,5,0, each held 4 cycles
  - scan_tick high for 1 cycle every 4
  - out = 8'h01 .. 8'h20, then 8'h01
- In SCAN at cur_code=3 mid-dwell, en=0 -> next cycle out = 8'h00, cur_code = 3, scan_tick = 0. Re-enabling SCAN gives a full 4-cycle dwell before advancing to 4.
- OUT_ACTIVE_LOW=1, direct code 2 -> out = 8'hFB. Assert Rst_n=0 asynchronously mid-cycle -> out = 8'hFF and cur_code = 0 immediately.
- Build without DECODER_SCAN_EN, mode=1, code_vld with code_in=6 -> out = 8'h40; scan_tick stays 0 throughout.

Source files
------------

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared FSM states, mode constants and sizing helper for decoder_scan_nx
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - combinational N to 2^N decoder with selectable polarity
module decoder_onehot #(
  parameter int N          = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic [N-1:0]        code,
  output logic [(1<<N)-1:0]   dec
);

  always_comb begin
    dec       = '0;
    dec[code] = 1'b1;
    if (ACTIVE_LOW != 0) dec = ~dec;
  end

endmodule

// File: rtl/decoder_scan_nx.sv
// rtl/decoder_scan_nx.sv - registered one-hot select decoder, direct or scanned codes
// Scan mode, dwell counter and scan_tick exist only when DECODER_SCAN_EN is defined.
module decoder_scan_nx
  import decoder_pkg::*;
#(
  parameter int N              = 3,
  parameter int DWELL          = 4,
  parameter int SCAN_LAST      = (1 << N) - 1,
  parameter int OUT_ACTIVE_LOW = 0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                en,
  input  logic                mode,
  input  logic [N-1:0]        code_in,
  input  logic                code_vld,
  output logic [(1<<N)-1:0]   out,
  output logic [N-1:0]        cur_code,
  output logic                scan_tick
);

  localparam int W = 1 << N;
  localparam logic [W-1:0] OFF = {W{(OUT_ACTIVE_LOW != 0)}};

  state_t         state, state_nxt;
  logic [N-1:0]   code_nxt;
  logic           tick_nxt;
  logic [W-1:0]   dec;

`ifdef DECODER_SCAN_EN
  localparam int CW = cnt_width(DWELL);
  logic [CW-1:0]  cnt, cnt_nxt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{mode, state, (DWELL > 1), (SCAN_LAST > 0)};
`endif

  always_comb begin
    code_nxt = cur_code;
    tick_nxt = 1'b0;
`ifdef DECODER_SCAN_EN
    cnt_nxt   = '0;
    state_nxt = !en ? IDLE : ((mode == MODE_SCAN) ? SCAN : DIRECT);
`else
    state_nxt = !en ? IDLE : DIRECT;
`endif
    case (state_nxt)
      DIRECT: if (code_vld) code_nxt = code_in;
`ifdef DECODER_SCAN_EN
      // The entry edge only loads a cleared count, so every code gets a full dwell.
      SCAN: if (state == SCAN) begin
        if (cnt == CW'(DWELL - 1)) begin
          code_nxt = (cur_code >= N'(SCAN_LAST)) ? '0 : cur_code + N'(1);
          tick_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`endif
      default: ;
    endcase
  end

  decoder_onehot #(.N(N), .ACTIVE_LOW(OUT_ACTIVE_LOW)) u_onehot (
    .code (code_nxt),
    .dec  (dec)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cur_code  <= '0;
      scan_tick <= 1'b0;
      out       <= OFF;
`ifdef DECODER_SCAN_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nxt;
      cur_code  <= code_nxt;
      scan_tick <= tick_nxt;
      out       <= (state_nxt == IDLE) ? OFF : dec;
`ifdef DECODER_SCAN_EN
      cnt       <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// tb/tb_decoder_scan_nx.sv - self-checking bench for decoder_scan_nx with a behavioural model
module tb_decoder_scan_nx;

  localparam int DWELL = 4;
  localparam int SL    = 5;
`ifdef DECODER_SCAN_EN
  localparam bit SCAN_BUILD = 1'b1;
`else
  localparam bit SCAN_BUILD = 1'b0;
`endif

  logic       Clk, Rst_n, en, mode, code_vld;
  logic [2:0] code_in;
  logic [7:0] out, out_al;
  logic [2:0] cur_code, cur_code_al;
  logic       scan_tick, scan_tick_al;

  int total = 0;
  int bad   = 0;

  // Reference model: which code is shown, whether the outputs are lit,
  // and how many cycles the shown code has been on display while scanning.
  int m_code, m_age;
  bit m_on, m_scan, m_tick;

  decoder_scan_nx #(.N(3), .DWELL(DWELL), .SCAN_LAST(SL), .OUT_ACTIVE_LOW(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .en(en), .mode(mode), .code_in(code_in),
    .code_vld(code_vld), .out(out), .cur_code(cur_code), .scan_tick(scan_tick)
  );

  decoder_scan_nx #(.N(3), .DWELL(DWELL), .SCAN_LAST(SL), .OUT_ACTIVE_LOW(1)) dut_al (
    .Clk(Clk), .Rst_n(Rst_n), .en(en), .mode(mode), .code_in(code_in),
    .code_vld(code_vld), .out(out_al), .cur_code(cur_code_al), .scan_tick(scan_tick_al)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_code = 0; m_age = 0; m_on = 0; m_scan = 0; m_tick = 0;
  endtask

  task automatic model_step();
    m_tick = 0;
    if (!en) begin
      m_on = 0; m_scan = 0; m_age = 0;
    end else if (!(mode && SCAN_BUILD)) begin
      m_on = 1; m_scan = 0; m_age = 0;
      if (code_vld) m_code = int'(code_in);
    end else begin
      m_on = 1;
      if (!m_scan) begin
        m_scan = 1; m_age = 1;
      end else if (m_age == DWELL) begin
        m_age  = 1;
        m_code = (m_code >= SL) ? 0 : m_code + 1;
        m_tick = 1;
      end else begin
        m_age++;
      end
    end
  endtask

  function automatic logic [7:0] exp_out(input bit al);
    logic [7:0] v;
    v = m_on ? (8'h01 << m_code) : 8'h00;
    return al ? ~v : v;
  endfunction

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; en = 0; mode = 0; code_vld = 0; code_in = 0;
    model_reset();
    #12;
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", out); end
    total++; if (out_al !== 8'hFF) begin bad++; $display("FAIL reset_out_al: got %h want ff", out_al); end
    total++; if (cur_code !== 3'd0) begin bad++; $display("FAIL reset_code: got %0d want 0", cur_code); end
    total++; if (scan_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", scan_tick); end
    Rst_n = 1'b1;
  endtask

  task automatic test_direct_walk();
    logic [7:0] one;
    en = 1; mode = 0;
    for (int i = 0; i < 8; i++) begin
      code_in = 3'(i); code_vld = 1;
      cycle();
      one = 8'h01 << i;
      total++; if (out !== one) begin bad++; $display("FAIL walk_out[%0d]: got %h want %h", i, out, one); end
      total++; if (out_al !== ~one) begin bad++; $display("FAIL walk_out_al[%0d]: got %h want %h", i, out_al, ~one); end
      total++; if (cur_code !== 3'(i)) begin bad++; $display("FAIL walk_code[%0d]: got %0d want %0d", i, cur_code, i); end
    end
    code_vld = 0;
  endtask

  task automatic test_hold();
    en = 1; mode = 0; code_vld = 0;
    for (int i = 0; i < 5; i++) begin
      code_in = 3'($urandom_range(0, 7));
      cycle();
      total++; if (out !== 8'h80) begin bad++; $display("FAIL hold_out: got %h want 80", out); end
      total++; if (cur_code !== 3'd7) begin bad++; $display("FAIL hold_code: got %0d want 7", cur_code); end
    end
  endtask

  task automatic test_idle();
    en = 1; mode = 0; code_in = 3'd5; code_vld = 1;
    cycle();
    en = 0; code_in = 3'd1;
    cycle();
    total++; if (out !== 8'h00) begin bad++; $display("FAIL idle_out: got %h want 00", out); end
    total++; if (cur_code !== 3'd5) begin bad++; $display("FAIL idle_code: got %0d want 5", cur_code); end
    en = 1; code_vld = 0;
    cycle();
    total++; if (out !== 8'h20) begin bad++; $display("FAIL reenter_out: got %h want 20", out); end
  endtask

`ifdef DECODER_SCAN_EN
  task automatic test_scan_seq();
    int code;
    en = 1; mode = 0; code_in = 3'd0; code_vld = 1;
    cycle();
    code_vld = 0; mode = 1;
    for (int j = 0; j < 28; j++) begin
      code_in = 3'($urandom_range(0, 7)); code_vld = 1'($urandom_range(0, 1));
      cycle();
      code = (j / DWELL) % (SL + 1);
      total++; if (cur_code !== 3'(code)) begin bad++; $display("FAIL scan_code[%0d]: got %0d want %0d", j, cur_code, code); end
      total++; if (out !== (8'h01 << code)) begin bad++; $display("FAIL scan_out[%0d]: got %h want %h", j, out, 8'h01 << code); end
      total++; if (scan_tick !== (j > 0 && j % DWELL == 0)) begin bad++; $display("FAIL scan_tick[%0d]: got %b", j, scan_tick); end
    end
    code_vld = 0;
  endtask

  task automatic test_scan_pause();
    en = 1; mode = 0; code_in = 3'd3; code_vld = 1;
    cycle();
    code_vld = 0; mode = 1;
    cycle();
    cycle();
    en = 0;
    cycle();
    total++; if (out !== 8'h00) begin bad++; $display("FAIL pause_out: got %h want 00", out); end
    total++; if (cur_code !== 3'd3) begin bad++; $display("FAIL pause_code: got %0d want 3", cur_code); end
    total++; if (scan_tick !== 1'b0) begin bad++; $display("FAIL pause_tick: got %b want 0", scan_tick); end
    en = 1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if (cur_code !== ((k < 4) ? 3'd3 : 3'd4) || scan_tick !== (k == 4)) begin
        bad++; $display("FAIL resume[%0d]: got code %0d tick %b", k, cur_code, scan_tick);
      end
    end
  endtask
`else
  task automatic test_no_scan();
    en = 1; mode = 1; code_in = 3'd6; code_vld = 1;
    cycle();
    total++; if (out !== 8'h40) begin bad++; $display("FAIL noscan_out: got %h want 40", out); end
    code_vld = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      total++;
      if (cur_code !== 3'd6 || scan_tick !== 1'b0 || out !== 8'h40) begin
        bad++; $display("FAIL noscan_hold[%0d]: got code %0d tick %b out %h", k, cur_code, scan_tick, out);
      end
    end
  endtask
`endif

  task automatic test_active_low_async_reset();
    en = 1; mode = 0; code_in = 3'd2; code_vld = 1;
    cycle();
    total++; if (out_al !== 8'hFB) begin bad++; $display("FAIL al_out: got %h want fb", out_al); end
    code_vld = 0;
    #3;
    Rst_n = 1'b0;
    #1;
    total++; if (out_al !== 8'hFF) begin bad++; $display("FAIL async_out_al: got %h want ff", out_al); end
    total++; if (out !== 8'h00) begin bad++; $display("FAIL async_out: got %h want 00", out); end
    total++; if (cur_code !== 3'd0) begin bad++; $display("FAIL async_code: got %0d want 0", cur_code); end
    #2;
    Rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    mode = 0;
    for (int i = 0; i < 300; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      code_vld = 1'($urandom_range(0, 1));
      code_in  = 3'($urandom_range(0, 7));
      cycle();
      total++;
      if (out !== exp_out(0) || out_al !== exp_out(1) || cur_code !== 3'(m_code) || scan_tick !== m_tick) begin
        bad++;
        $display("FAIL random[%0d]: got out %h al %h code %0d tick %b want %h %h %0d %b",
                 i, out, out_al, cur_code, scan_tick, exp_out(0), exp_out(1), m_code, m_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_walk();
    test_hold();
    test_idle();
`ifdef DECODER_SCAN_EN
    test_scan_seq();
    test_scan_pause();
`else
    test_no_scan();
`endif
    test_active_low_async_reset();
    en = 0; mode = 0; code_vld = 0;
    cycle();
    model_reset();
    m_code = int'(cur_code);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
